// File: rtl/fetch_queue_if.sv
// fetch_queue_if: fetch request/response, redirect and instruction handshake.
// master = queue side (drives fetch_req/pc, inst*, count); slave = environment.
interface fetch_queue_if #(
    parameter int FETCH_BYTES = 2,
    parameter int DEPTH       = 8,
    parameter int ADDR_W      = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                     fetch_req;
    logic [ADDR_W-1:0]        fetch_pc;
    logic                     fetch_valid;
    logic [8*FETCH_BYTES-1:0] fetch_data;
    logic                     redirect;
    logic [ADDR_W-1:0]        redirect_pc;
    logic                     inst_valid;
    logic                     inst_ready;
    logic [23:0]              inst;
    logic [1:0]               inst_len;
    logic [ADDR_W-1:0]        inst_pc;
    logic [CW-1:0]            count;

    modport master (
        output fetch_req,
        output fetch_pc,
        input  fetch_valid,
        input  fetch_data,
        input  redirect,
        input  redirect_pc,
        output inst_valid,
        input  inst_ready,
        output inst,
        output inst_len,
        output inst_pc,
        output count
    );

    modport slave (
        input  fetch_req,
        input  fetch_pc,
        output fetch_valid,
        output fetch_data,
        output redirect,
        output redirect_pc,
        input  inst_valid,
        output inst_ready,
        input  inst,
        input  inst_len,
        input  inst_pc,
        input  count
    );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: 8080 prefetch byte queue, length-decodes head, issues aligned insts.
// Ports: clk, rst_n (async, active-low), bus (fetch_queue_if.master).
module fetch_queue #(
    parameter int FETCH_BYTES = 2,
    parameter int DEPTH       = 8,
    parameter int ADDR_W      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_queue_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FB_C    = CW'(FETCH_BYTES);
    localparam logic [CW:0]   FB_W    = (CW+1)'(FETCH_BYTES);
    localparam logic [CW:0]   DEPTH_W = (CW+1)'(DEPTH);

    typedef logic [PW-1:0] ptr_t;

    logic [7:0]        mem [DEPTH];
    ptr_t              head;
    ptr_t              tail;
    logic [CW-1:0]     count_q;
    logic              outstanding;
    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] inst_pc_q;

    logic [7:0]    b0;
    logic [7:0]    b1;
    logic [7:0]    b2;
    logic [1:0]    len;
    logic          valid;
    logic          pop;
    logic          push;
    logic          req;
    logic [CW:0]   room_need;
    logic [CW:0]   fill_chk;
    logic [CW-1:0] count_n;

    function automatic logic [1:0] op_len(input logic [7:0] op);
        logic is3;
        logic is2;
        logic [1:0] l;
        l   = 2'd1;
        is3 = (op[7:6] == 2'b00 && op[3:0] == 4'h1)
            || (op[7:5] == 3'b001 && op[2:0] == 3'b010)
            || (op == 8'hC3) || (op == 8'hCD)
            || (op[7:6] == 2'b11 && op[2:0] == 3'b010)
            || (op[7:6] == 2'b11 && op[2:0] == 3'b100);
        is2 = (op[7:6] == 2'b00 && op[2:0] == 3'b110)
            || (op[7:6] == 2'b11 && op[2:0] == 3'b110)
            || (op == 8'hD3) || (op == 8'hDB);
        unique case (1'b1)
            is3:     l = 2'd3;
            is2:     l = 2'd2;
            default: l = 2'd1;
        endcase
        return l;
    endfunction

    always_comb begin
        b0    = mem[head];
        b1    = mem[head + ptr_t'(1)];
        b2    = mem[head + ptr_t'(2)];
        len   = op_len(b0);
        valid = (count_q != '0)
              && (count_q >= CW'(len))
              && !bus.redirect;
        pop   = valid && bus.inst_ready;
        push  = bus.fetch_valid && outstanding
              && !bus.redirect;
        // Space is reserved for the in-flight response,
        // so a granted request can never overflow.
        room_need = {1'b0, count_q} + FB_W
                  + (outstanding ? FB_W : '0);
        req = rst_n && !bus.redirect
            && (room_need <= DEPTH_W);
        count_n = count_q
                + (push ? FB_C : '0)
                - (pop ? CW'(len) : '0);
        fill_chk = {1'b0, count_q}
                 + (push ? FB_W : '0)
                 - (pop ? (CW+1)'(len) : '0);
    end

    assign bus.fetch_req  = req;
    assign bus.fetch_pc   = fetch_pc_q;
    assign bus.inst_valid = valid;
    assign bus.inst_len   = len;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.count      = count_q;
    assign bus.inst = {
        b0,
        (len != 2'd1) ? b1 : 8'h00,
        (len == 2'd3) ? b2 : 8'h00
    };

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head        <= '0;
            tail        <= '0;
            count_q     <= '0;
            outstanding <= 1'b0;
            fetch_pc_q  <= '0;
            inst_pc_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.redirect) begin
            head        <= '0;
            tail        <= '0;
            count_q     <= '0;
            outstanding <= 1'b0;
            fetch_pc_q  <= bus.redirect_pc;
            inst_pc_q   <= bus.redirect_pc;
        end else begin
            outstanding <= req;
            if (req) begin
                fetch_pc_q <= fetch_pc_q
                            + ADDR_W'(FETCH_BYTES);
            end
            if (push) begin
                assert (fill_chk <= DEPTH_W)
                    else $error("fetch_queue overflow");
                for (int i = 0; i < FETCH_BYTES; i++) begin
                    mem[tail + ptr_t'(i)] <=
                        bus.fetch_data[8*i +: 8];
                end
                tail <= tail + ptr_t'(FETCH_BYTES);
            end
            if (pop) begin
                head      <= head + ptr_t'(len);
                inst_pc_q <= inst_pc_q + ADDR_W'(len);
            end
            count_q <= count_n;
        end
    end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised instruction prefetch/alignment queue for the 8080 pipeline. It sits between memory fetch and decode.
- Issues sequential multi-byte fetches and buffers returned bytes in a circular byte queue.
- Length-decodes the head opcode (1/2/3 bytes) and presents one aligned instruction per handshake to decode.
- Supports flush/redirect for jumps, calls and returns.

Parameters:
FETCH_BYTES, 2, bytes returned per fetch; allowed range 1..4.
DEPTH, 8, queue capacity in bytes; power of two, and DEPTH >= max(4, 2*FETCH_BYTES).
ADDR_W, 16, address width.

Ports:
clk  in  1  clock; all state updates on posedge.
rst_n  in  1  reset, asynchronous, active-low.
fetch_req  out  1  fetch request this cycle.
fetch_pc  out  ADDR_W  address of first byte requested.
fetch_valid  in  1  response valid; arrives exactly one cycle after its fetch_req.
fetch_data  in  8*FETCH_BYTES  response bytes, little-endian (byte at fetch_pc in [7:0]).
redirect  in  1  flush queue and restart fetch at redirect_pc.
redirect_pc  in  ADDR_W  new fetch/instruction address.
inst_valid  out  1  complete instruction at queue head.
inst_ready  in  1  decode accepts the head instruction.
inst  out  24  {opcode, byte2, byte3}: opcode in [23:16], byte2 in [15:8], byte3 in [7:0]. Bytes beyond inst_len read as 0.
inst_len  out  2  1, 2 or 3.
inst_pc  out  ADDR_W  address of the opcode byte.
count  out  log2(DEPTH)+1  bytes currently held.

Behaviour:
- Reset (async, rst_n=0):
  - Queue empty; head/tail pointers 0; count=0.
  - fetch_req=0; fetch_pc=0; inst_pc=0; inst_valid=0; inst=0; inst_len=1; outstanding flag=0.
- Length decode (combinational on head byte):
  - 3 bytes: 00rp0001 (LXI); 22h, 2Ah, 32h, 3Ah, C3h, CDh; 11ccc010 (Jccc); 11ccc100 (Cccc).
  - 2 bytes: 00ddd110 (MVI); C6h, CEh, D6h, DEh, E6h, EEh, F6h, FEh, D3h, DBh.
  - All other opcodes: 1 byte.
- inst_valid = (count >= 1) && (count >= inst_len) && !redirect. Outputs derive from registered state plus the redirect gate only.
- Pop:
  - Occurs when inst_valid && inst_ready.
  - Head pointer advances by inst_len modulo DEPTH.
  - inst_pc advances by inst_len modulo 2^ADDR_W.
  - Bytes may straddle pointer wrap; they are read across the wrap.
- Fetch issue:
  - fetch_req = !redirect && (DEPTH - count - (outstanding ? FETCH_BYTES : 0) >= FETCH_BYTES). Count is the pre-pop value, so the decision is conservative.
  - Each cycle fetch_req=1: fetch_pc <= fetch_pc + FETCH_BYTES (wraps modulo 2^ADDR_W), and outstanding <= 1 for the next cycle.
  - A cycle with no fetch_req clears outstanding.
- Push:
  - On fetch_valid && outstanding && !redirect, FETCH_BYTES bytes are written at the tail, then the tail advances.
  - fetch_valid with outstanding=0 is ignored.
- Simultaneous push and pop in one cycle are allowed: count <= count + push*FETCH_BYTES - pop*inst_len.
- Invariant: count never exceeds DEPTH. An assertion fires if a push would overflow.
- Redirect (highest priority):
  - In the redirect cycle, the handshake is void: inst_valid is forced 0, no pop occurs, any fetch_valid is dropped, and fetch_req=0.
  - Next edge: queue cleared; count=0; outstanding=0; fetch_pc <= redirect_pc; inst_pc <= redirect_pc.
  - First new request is issued in the following cycle.
  - First instruction is visible no earlier than 2 cycles after redirect deasserts: request, response, then a registered push.
- Back-to-back redirects: the last one wins. There is no fetch between them.
- Latency from empty: fetch_req at T, data at T+1, inst_valid at T+2, provided enough bytes have arrived for the head length.
- A 3-byte instruction with FETCH_BYTES=2 needs two pushes; inst_valid stays low until count >= 3.
- Reset mid-operation: all state clears immediately. Any response arriving after release is ignored because outstanding=0.

Test Plan:
1. Reset, then release with memory returning 00h,3Eh,42h,C3h,34h,12h from address 0 and inst_ready=1. Expect NOP (inst=000000h, len 1, pc 0), then MVI A (3E4200h, len 2, pc 1), then JMP (C33412h, len 3, pc 3). The first inst_valid occurs 2 cycles after the first fetch_req.
2. Hold inst_ready=0 with a stream of NOPs. Expect count to saturate at DEPTH=8 and fetch_req to stop, with no overflow. Raise inst_ready: 8 NOPs drain at 1 per cycle and fetching resumes.
3. Place a 3-byte LXI (21h,00h,80h) so it straddles the queue wrap (head at index 7). Expect inst=210080h, len 3.
4. Assert redirect with redirect_pc=0100h while a response is arriving and inst_valid=1 and inst_ready=1. Expect the response dropped, no pop, count=0 next cycle, fetch_pc=0100h, and the next inst_pc=0100h.
5. Assert rst_n=0 asynchronously mid-stream between clock edges. Expect outputs to clear immediately. After release, a stray fetch_valid is ignored (count stays 0).
6. With FETCH_BYTES=1 and DEPTH=4, run the stream from scenario 1. Expect an identical instruction sequence, with the JMP held until 3 bytes are present.
